// File: rtl/maxpool_unit.sv
// maxpool_unit: 2x2 stride-2 signed max-pooling over an IMG_W x IMG_W map
// held in a single-port feature memory. Pooled results are written back
// through the same port, one output every 6 cycles.
//
// Build option: define MAXPOOL_RELU_EN to clamp negative results to zero.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      run request, sampled while idle
//   busy       high while a run is in progress
//   done       one-cycle pulse after the last output write
//   mem_addr   feature-memory address (read or write)
//   mem_rdata  read data for the address presented in the previous cycle
//   mem_wdata  pooled result
//   mem_we     write strobe
module maxpool_unit #(
   parameter int unsigned IMG_W    = 64,
   parameter logic [11:0] SRC_BASE = 12'd0,
   parameter logic [11:0] DST_BASE = 12'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [11:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata,
   output logic        mem_we
);

   localparam int unsigned AW   = 12;
   localparam int unsigned DW   = 32;
   localparam int unsigned HALF = IMG_W / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0] C_LAST     = CW'(HALF - 1);
   localparam logic [AW-1:0] ROW_STRIDE = AW'(2 * IMG_W);
   localparam logic [AW-1:0] IMG_W_A    = AW'(IMG_W);
   localparam logic [AW-1:0] HALF_A     = AW'(HALF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_RD2,
      S_RD3,
      S_CMP,
      S_WR,
      S_FIN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   r_q, r_d;
   logic [CW-1:0]   c_q, c_d;
   logic [DW-1:0]   max_q, max_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic [DW-1:0]   max_upd;
   logic [DW-1:0]   wr_val;
   logic [AW-1:0]   win_base;
   logic [AW-1:0]   dst_addr;

   // State, counters, running max and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         c_q     <= '0;
         max_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         max_q   <= max_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next state, counters, running max, and outputs for the state being entered
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      max_d   = max_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      // Ties keep the earlier value; bit-identical either way
      max_upd = ($signed(mem_rdata) > $signed(max_q)) ? mem_rdata : max_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD0;
               r_d     = '0;
               c_d     = '0;
            end
         end
         S_RD0: state_d = S_RD1;
         S_RD1: begin
            state_d = S_RD2;
            max_d   = mem_rdata;
         end
         S_RD2: begin
            state_d = S_RD3;
            max_d   = max_upd;
         end
         S_RD3: begin
            state_d = S_CMP;
            max_d   = max_upd;
         end
         S_CMP: begin
            state_d = S_WR;
            max_d   = max_upd;
         end
         S_WR: begin
            state_d = S_RD0;
            if (c_q == C_LAST) begin
               c_d = '0;
               if (r_q == C_LAST) begin
                  r_d     = '0;
                  state_d = S_FIN;
               end else begin
                  r_d = r_q + CW'(1);
               end
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Addresses for the output the machine is about to work on (mod 4096)
      win_base = SRC_BASE + AW'(r_d) * ROW_STRIDE + AW'({c_d, 1'b0});
      dst_addr = DST_BASE + AW'(r_d) * HALF_A + AW'(c_d);

`ifdef MAXPOOL_RELU_EN
      wr_val = max_d[DW-1] ? '0 : max_d;
`else
      wr_val = max_d;
`endif

      unique case (state_d)
         S_RD0: begin
            busy_d = 1'b1;
            addr_d = win_base;
         end
         S_RD1: begin
            busy_d = 1'b1;
            addr_d = win_base + AW'(1);
         end
         S_RD2: begin
            busy_d = 1'b1;
            addr_d = win_base + IMG_W_A;
         end
         S_RD3: begin
            busy_d = 1'b1;
            addr_d = win_base + IMG_W_A + AW'(1);
         end
         S_CMP: busy_d = 1'b1;
         S_WR: begin
            busy_d  = 1'b1;
            we_d    = 1'b1;
            addr_d  = dst_addr;
            wdata_d = wr_val;
         end
         S_FIN:  done_d = 1'b1;
         default: begin
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_maxpool_unit.sv
// Testbench for maxpool_unit: two instances (in-place and offset destination)
// sharing clock, reset and start, each with its own 4096x32 memory model.
module tb_maxpool_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;

   logic        busy_a, done_a, we_a;
   logic [11:0] addr_a;
   logic [31:0] rdata_a, wdata_a;
   logic        busy_b, done_b, we_b;
   logic [11:0] addr_b;
   logic [31:0] rdata_b, wdata_b;

   logic [31:0] mem_a [4096];
   logic [31:0] mem_b [4096];

   logic        ld_ramp;
   logic        patch_en;
   logic [11:0] patch_addr;
   logic [31:0] patch_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   maxpool_unit u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy_a),
      .done      (done_a),
      .mem_addr  (addr_a),
      .mem_rdata (rdata_a),
      .mem_wdata (wdata_a),
      .mem_we    (we_a)
   );

   maxpool_unit #(.IMG_W(64), .SRC_BASE(12'd0), .DST_BASE(12'hC00)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy_b),
      .done      (done_b),
      .mem_addr  (addr_b),
      .mem_rdata (rdata_b),
      .mem_wdata (wdata_b),
      .mem_we    (we_b)
   );

   // Single-port memories with one-cycle read latency
   always @(posedge clk) begin
      rdata_a <= mem_a[addr_a];
      if (ld_ramp) begin
         for (int i = 0; i < 4096; i++) mem_a[i] <= 32'(i);
      end else if (patch_en) begin
         mem_a[patch_addr] <= patch_data;
      end else if (we_a) begin
         mem_a[addr_a] <= wdata_a;
      end
   end

   always @(posedge clk) begin
      rdata_b <= mem_b[addr_b];
      if (ld_ramp) begin
         for (int i = 0; i < 4096; i++) mem_b[i] <= 32'(i);
      end else if (we_b) begin
         mem_b[addr_b] <= wdata_b;
      end
   end

   typedef struct {
      string       name;
      int unsigned addr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [4];

   int          done_cyc, done_b_cyc, we_cnt, busy_low;
   logic        busy1, busy1_b, busy_at_done;
   logic [11:0] addr_log [1:8];
   logic        we_log   [1:8];
   bit          aborted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load_ramp();
      @(negedge clk) ld_ramp = 1'b1;
      @(negedge clk) ld_ramp = 1'b0;
   endtask

   task automatic patch(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      patch_addr = a;
      patch_data = d;
      patch_en   = 1'b1;
      @(negedge clk) patch_en = 1'b0;
   endtask

   // Start a run and follow it cycle by cycle (cycle 1 = cycle after the start edge)
   task automatic run(input int pulse_at, input int abort_at);
      int k;
      bit fin;
      done_cyc = 0; done_b_cyc = 0; we_cnt = 0; busy_low = 0;
      aborted = 1'b0; fin = 1'b0; busy_at_done = 1'b1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 1;
      while (!fin) begin
         if (k <= 8) begin
            addr_log[k] = addr_a;
            we_log[k]   = we_a;
         end
         if (k == 1) begin
            busy1   = busy_a;
            busy1_b = busy_b;
         end
         if (we_a) we_cnt++;
         if (done_b && done_b_cyc == 0) done_b_cyc = k;
         if (done_a) begin
            done_cyc     = k;
            busy_at_done = busy_a;
            fin          = 1'b1;
         end else if (!busy_a) begin
            busy_low++;
         end
         if (!fin) begin
            if (k == abort_at) begin
               #1 reset = 1'b0;
               aborted = 1'b1;
               fin     = 1'b1;
            end else if (k >= 7000) begin
               fin = 1'b1;
            end else begin
               start = (k == pulse_at);
               @(posedge clk);
               #1 k++;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic check_ramp_result(input string tag);
      int bad;
      for (int i = 0; i < 4; i++)
         chk({tag, "_", tbl[i].name}, mem_a[tbl[i].addr], tbl[i].exp);
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
         if (mem_a[k] !== 32'(128 * (k / 32) + 2 * (k % 32) + 65)) bad++;
      end
      chk({tag, "_all_outputs_bad_count"}, 32'(bad), 32'd0);
   endtask

   task automatic check_run_stats(input string tag);
      chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd6145);
      chk({tag, "_we_pulses"}, 32'(we_cnt), 32'd1024);
      chk({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
      chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      @(posedge clk);
      #1 chk({tag, "_done_pulse_width"}, 32'(done_a), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      logic [31:0] neg_exp;

      tbl[0] = '{name: "out0",    addr: 0,    exp: 32'h0000_0041};
      tbl[1] = '{name: "out1",    addr: 1,    exp: 32'h0000_0043};
      tbl[2] = '{name: "out32",   addr: 32,   exp: 32'h0000_00C1};
      tbl[3] = '{name: "out1023", addr: 1023, exp: 32'h0000_0FFF};

      reset = 1'b0; start = 1'b0; ld_ramp = 1'b0; patch_en = 1'b0;
      patch_addr = '0; patch_data = '0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);

      // Reset pulsed mid-cycle, then held with start low
      #3 reset = 1'b0;
      #1 chk("reset_outputs", {busy_a, done_a, we_a, addr_a, wdata_a[18:0]} | {32{|wdata_a}}, 32'd0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 if (busy_a || done_a || we_a) bad++;
      end
      chk("reset_hold_idle", 32'(bad), 32'd0);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_after_reset", {29'd0, busy_a, done_a, we_a}, 32'd0);

      // Ramp run, both instances
      load_ramp();
      run(-1, -1);
      chk("t_addr_c1", 32'(addr_log[1]), 32'd0);
      chk("t_addr_c2", 32'(addr_log[2]), 32'd1);
      chk("t_addr_c3", 32'(addr_log[3]), 32'd64);
      chk("t_addr_c4", 32'(addr_log[4]), 32'd65);
      chk("t_we_c5", 32'(we_log[5]), 32'd0);
      chk("t_we_c6", 32'(we_log[6]), 32'd1);
      chk("t_addr_c6", 32'(addr_log[6]), 32'd0);
      chk("t_we_c7", 32'(we_log[7]), 32'd0);
      chk("t_busy_c1", 32'(busy1), 32'd1);
      chk("b_busy_c1", 32'(busy1_b), 32'd1);
      chk("b_done_cycle", 32'(done_b_cyc), 32'd6145);
      check_run_stats("ramp");
      check_ramp_result("ramp");

      chk("offset_C00", mem_b[12'hC00], 32'h0000_0041);
      chk("offset_FFF", mem_b[12'hFFF], 32'h0000_0FFF);
      bad = 0;
      for (int i = 0; i < 12'hC00; i++) if (mem_b[i] !== 32'(i)) bad++;
      chk("offset_src_unchanged_bad", 32'(bad), 32'd0);

      // Start pulsed while busy is ignored
      load_ramp();
      run(100, -1);
      check_run_stats("busy_start");
      check_ramp_result("busy_start");

      // Reset mid-run, then a fresh start from output (0,0)
      load_ramp();
      run(-1, 3000);
      chk("abort_reached", 32'(aborted), 32'd1);
      #1 chk("abort_outputs", {busy_a, done_a, we_a, addr_a, wdata_a[18:0]} | {32{|wdata_a}}, 32'd0);
      @(negedge clk) reset = 1'b1;
      load_ramp();
      run(-1, -1);
      chk("restart_addr_c1", 32'(addr_log[1]), 32'd0);
      check_run_stats("restart");
      check_ramp_result("restart");

      // Negative window at output 0
`ifdef MAXPOOL_RELU_EN
      neg_exp = 32'h0000_0000;
`else
      neg_exp = 32'hFFFF_FFFF;
`endif
      load_ramp();
      patch(12'd0,  -32'sd5);
      patch(12'd1,  -32'sd3);
      patch(12'd64, -32'sd8);
      patch(12'd65, -32'sd1);
      run(-1, -1);
      chk("neg_done_cycle", 32'(done_cyc), 32'd6145);
      chk("neg_window", mem_a[0], neg_exp);
      chk("neg_out1_unaffected", mem_a[1], 32'h0000_0043);

      // Extreme signed values: most positive must win over most negative
      load_ramp();
      patch(12'd0,  32'h8000_0000);
      patch(12'd1,  32'h8000_0000);
      patch(12'd64, 32'h8000_0000);
      patch(12'd65, 32'h7FFF_FFFF);
      run(-1, -1);
      chk("ext_window", mem_a[0], 32'h7FFF_FFFF);

      load_ramp();
      patch(12'd0,  32'h7FFF_FFFF);
      patch(12'd1,  32'h8000_0000);
      patch(12'd64, 32'h8000_0000);
      patch(12'd65, 32'h8000_0000);
      run(-1, -1);
      chk("ext_window_first", mem_a[0], 32'h7FFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/maxpool_unit.md
# maxpool_unit

Layer-1 stage of the CNN accelerator: 2x2, stride-2 signed max-pooling over the 64x64 layer-0 convolution map held in feature memory, producing the 32x32 (1024-word) layer-1 map. It sits directly downstream of the convolution stage in `processor_ctrl`. It shares the single-port 4096x32 feature memory, reading conv results and writing pooled results back through the same port. The controller starts it once `instruction_finish` indicates layer 0 is complete.

## Interface
- `IMG_W`, 64: source map width and height in words; power of two, 2..64.
- `SRC_BASE`, 12'd0: feature-memory address of source pixel (0,0).
- `DST_BASE`, 12'd0: feature-memory address of output pixel (0,0).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: run request, sampled on the rising edge while idle.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse after the last output write.
- `mem_addr` out 12: feature-memory address, read or write.
- `mem_rdata` in 32: signed read data for the address presented in the previous cycle.
- `mem_wdata` out 32: signed pooled result.
- `mem_we` out 1: write strobe; memory captures `mem_wdata` at `mem_addr` on the rising edge.

## Operation
- All outputs are registered. Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. The state machine resets to IDLE with row and column counters at 0.
- States are IDLE → RD0 → RD1 → RD2 → RD3 → CMP → WR, then either RD0 (more outputs) or FIN → IDLE.
- Window addresses for output (r,c), with b = `SRC_BASE` + 2r·`IMG_W` + 2c:
  - A0 = b
  - A1 = b+1
  - A2 = b+`IMG_W`
  - A3 = b+`IMG_W`+1
  - Address arithmetic is modulo 4096.
- Per-state behaviour:
  - RD0 presents A0.
  - RD1 presents A1 and loads max ← rdata.
  - RD2 presents A2 and sets max ← smax(max, rdata).
  - RD3 presents A3 and sets max ← smax(max, rdata).
  - CMP sets max ← smax(max, rdata).
  - WR drives `mem_addr` = `DST_BASE` + r·(`IMG_W`/2) + c, `mem_wdata` = max, `mem_we` = 1.
- smax is a full 32-bit two's-complement signed compare. On ties the earlier value is kept (values are bit-identical, so the result is the same either way).
- Counters: c increments after WR. On c = `IMG_W`/2−1, c wraps to 0 and r increments. WR with r = c = `IMG_W`/2−1 goes to FIN.
- FIN: `done`=1, `busy`=0, then IDLE. `mem_we` is 0 in every state except WR.
- `start` is ignored in every non-IDLE state and in the FIN cycle.
- `reset` asserted mid-run: immediate return to the reset values, with no partial write completed after the reset edge. A fresh `start` restarts from output (0,0).
- In-place operation is safe when `DST_BASE` ≤ `SRC_BASE`: every write address is at or below the lowest address still to be read.

## Timing
- With `start` sampled on edge E0, RD0 occupies the cycle after E0 and `busy` rises in that same cycle.
- Each output takes 6 cycles. Writes occur in cycles 6, 12, …, 6·N, where N = (`IMG_W`/2)².
- `done` is high in cycle 6·N+1. For the default N = 1024, that is cycle 6145.
- Read latency is fixed at one cycle. `mem_rdata` is sampled on the edge that ends the cycle after the address was presented.

## Configuration
- `MAXPOOL_RELU_EN` defined: the written value is max(result, 0). Negative pooled results are written as 32'h0000_0000.
- `MAXPOOL_RELU_EN` undefined: the signed maximum is written unchanged.
- Timing and state sequence are identical in both builds.

## Test plan
- Reset: pulse `reset` low mid-cycle. All outputs read 0 immediately; hold 10 cycles with `start`=0. `busy`, `done` and `mem_we` stay 0.
- Ramp: mem[i] = i for i < 4096, defaults, start → out[0]=0x41, out[1]=0x43, out[32]=0xC1, out[1023]=0xFFF. `done` is in cycle 6145 and there are exactly 1024 `mem_we` pulses.
- Negatives: window {−5, −3, −8, −1} at output 0 → 0xFFFF_FFFF without `MAXPOOL_RELU_EN`, 0x0000_0000 with it. Window {0x8000_0000 ×3, 0x7FFF_FFFF} → 0x7FFF_FFFF in both builds.
- Cycle timing: start sampled at E0 → `mem_addr`=0 in cycle 1, 1 in cycle 2, 64 in cycle 3, 65 in cycle 4. `mem_we`=1 with `mem_addr`=0 in cycle 6 only.
- Start while busy: pulse `start` at cycle 100 → no restart, and results match the ramp case. Then assert `reset` at cycle 3000 and restart → full correct output and `done` 6145 cycles after the new start.
- Offset bases: `SRC_BASE`=0, `DST_BASE`=12'hC00 with the ramp → mem[0xC00]=0x41 and mem[0xFFF]=0xFFF, with source words below 0xC00 unchanged.
